tlk2711_axi_mem_resp: RTL
=========================

Name: tlk2711_axi_mem_resp

Overview:
- AXI4 memory-mapped responder (slave) backed by an internal RAM array; the far end of the DMA master's m_axi read and write channels.
- Lets the TLK2711 TX read path and RX write path run on a bench or in a PL-only loopback build without the PS DDR.
- Independent read and write engines share one simple dual-port RAM.

Parameters:
- ADDR_WIDTH, 48, AXI address width.
- DATA_WIDTH, 64, AXI data width; fixed 8 bytes per beat.
- WBYTE_WIDTH, 8, write strobe width (DATA_WIDTH/8).
- MEM_AW, 12, log2 of RAM depth in DATA_WIDTH words (default 4096 words = 32 KB).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_arvalid/arready  in/out  1/1  read address handshake.
- s_axi_arid  in  4  read ID, echoed on rid.
- s_axi_araddr  in  ADDR_WIDTH  byte address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_arsize  in  3  beat size.
- s_axi_arburst  in  2  burst type.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rid  out  4  read response ID.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid/rready  out/in  1/1  read data handshake.
- s_axi_awvalid/awready  in/out  1/1  write address handshake.
- s_axi_awid  in  4  write ID, echoed on bid.
- s_axi_awaddr  in  ADDR_WIDTH  byte address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awsize  in  3  beat size.
- s_axi_awburst  in  2  burst type.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  WBYTE_WIDTH  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid/wready  in/out  1/1  write data handshake.
- s_axi_bid  out  4  write response ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid/bready  out/in  1/1  write response handshake.
- o_rd_burst_cnt  out  32  completed read bursts.
- o_wr_burst_cnt  out  32  completed write bursts.

Behaviour:
- Reset (async, rst_n low):
  - arready=1, awready=1.
  - rvalid=0, rlast=0, rdata=0, rresp=0, rid=0.
  - wready=0, bvalid=0, bresp=0, bid=0.
  - Both counters = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-burst abandons the burst; no response is issued.
- Word index = addr[MEM_AW+2:3]. Address bits above that range are ignored, so access aliases modulo depth. Bits [2:0] are ignored. Incrementing index wraps modulo 2^MEM_AW.
- A burst is legal when burst==2'b01 (INCR) and size==3'b011. Otherwise the response is SLVERR (2'b10) and the full arlen+1 / awlen+1 beats are still honoured. Illegal reads return rdata=0; illegal writes do not modify RAM.
- Read FSM states RD_IDLE → RD_DATA:
  - RD_IDLE: arready=1. The AR handshake in cycle T latches addr, len, id and legality; arready drops at T+1.
  - RD_DATA: rvalid first high at T+1 with mem[idx0]. A beat completes on rvalid&rready; the next word appears the following cycle, giving back-to-back beats while rready stays high.
  - rdata, rlast, rresp and rid are held stable while rvalid&!rready.
  - rlast is high on beat arlen only.
  - After the last handshake: rvalid=0, o_rd_burst_cnt+1, return to RD_IDLE with arready=1 the next cycle.
  - No AR pipelining: one outstanding read.
- Write FSM states WR_IDLE → WR_DATA → WR_RESP:
  - WR_IDLE: awready=1, wready=0. The AW handshake latches addr, len, id and legality; go to WR_DATA.
  - WR_DATA: wready=1. Each wvalid&wready writes the bytes with a set wstrb bit into mem[idx] in that cycle, then idx increments.
  - The burst ends on beat awlen, whatever wlast says. A protocol error flag is set if wlast is high on an earlier beat or low on beat awlen.
  - WR_RESP: wready=0, bvalid=1, bid=latched id. bresp=SLVERR if the burst was illegal or the protocol error flag is set, else OKAY. On bready: bvalid=0, o_wr_burst_cnt+1, go to WR_IDLE.
- Read/write collision on the same word in the same cycle: read-first. The read beat returns old data; new data is visible to any later read.
- Counters wrap at 2^32.

Test Plan:
- Write AW addr=0x100, len=3, wstrb=FF, data 1..4, bready=1 → bvalid one cycle after the 4th beat, bresp=0, bid echoed. Then AR addr=0x100, len=3 → rdata 1,2,3,4, rlast on beat 3, rvalid first at T+1, o_rd_burst_cnt=1.
- Toggle rready randomly (50%) during a 16-beat read → data held stable across stalls, no beats lost or duplicated, rlast only on beat 15.
- Partial strobes: write 0xFFFF_FFFF_FFFF_FFFF, then wstrb=0x0F with data 0 → readback 0xFFFF_FFFF_0000_0000.
- Wrap: with MEM_AW=12, write at word 4095 with len=1 → second beat lands at word 0. Read at addr 0x8000 returns word 0.
- Illegal: arburst=2'b00 with len=2 → 3 beats, rresp=2'b10, rdata=0. Early wlast on beat 1 of a len=3 write → 4 beats accepted, bresp=2'b10.
- Pull rst_n low mid-read burst → rvalid=0 immediately (async), arready=1 after release, counters 0, prior RAM data intact on the next read.

Source files
------------

// File: rtl/tlk2711_axi_mem_resp.sv
// AXI4 memory-mapped responder backed by a simple dual-port RAM.
// Stands in for PS DDR so the TLK2711 DMA read/write paths can loop back in PL.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RD_IDLE  | arready high, waiting for a read address
// RD_DATA  | streaming read beats, rvalid high
// WR_IDLE  | awready high, waiting for a write address
// WR_DATA  | wready high, accepting write beats into RAM
// WR_RESP  | bvalid high, waiting for bready
module tlk2711_axi_mem_resp #(
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 64,
  parameter int WBYTE_WIDTH = 8,
  parameter int MEM_AW      = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  input  logic [3:0]             s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [7:0]             s_axi_arlen,
  input  logic [2:0]             s_axi_arsize,
  input  logic [1:0]             s_axi_arburst,
  output logic [DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [3:0]             s_axi_rid,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [3:0]             s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic [7:0]             s_axi_awlen,
  input  logic [2:0]             s_axi_awsize,
  input  logic [1:0]             s_axi_awburst,
  input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [WBYTE_WIDTH-1:0] s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [3:0]             s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  output logic [31:0]            o_rd_burst_cnt,
  output logic [31:0]            o_wr_burst_cnt
);

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MEM_DEPTH = 1 << MEM_AW;

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  // Byte offset and address bits above the RAM depth are don't-care (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr[ADDR_WIDTH-1:MEM_AW+3], s_axi_araddr[2:0],
                              s_axi_awaddr[ADDR_WIDTH-1:MEM_AW+3], s_axi_awaddr[2:0]};

  // ---------------- read engine ----------------
  logic [0:0]            rd_state;
  logic [MEM_AW-1:0]     rd_idx;
  logic [MEM_AW-1:0]     ar_idx;
  logic [MEM_AW-1:0]     rd_fetch_idx;
  logic [7:0]            rd_beat;
  logic [7:0]            rd_len;
  logic                  rd_legal;
  logic                  ar_legal;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ar_idx       = s_axi_araddr[MEM_AW+2:3];
  assign ar_legal     = (s_axi_arburst == 2'b01) && (s_axi_arsize == 3'b011);
  assign rd_fetch_idx = (rd_state == RD_IDLE) ? ar_idx : rd_idx;
  assign rd_word      = mem[rd_fetch_idx];

  assign s_axi_arready = (rd_state == RD_IDLE);
  assign s_axi_rvalid  = (rd_state == RD_DATA);
  assign s_axi_rlast   = s_axi_rvalid && (rd_beat == rd_len);

  // rdata is registered at the fetch edge, so a same-cycle write to that word
  // lands after the read sample (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state       <= RD_IDLE;
      rd_idx         <= '0;
      rd_beat        <= '0;
      rd_len         <= '0;
      rd_legal       <= 1'b0;
      s_axi_rdata    <= '0;
      s_axi_rid      <= '0;
      s_axi_rresp    <= RESP_OKAY;
      o_rd_burst_cnt <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s_axi_arvalid) begin
            rd_state    <= RD_DATA;
            rd_idx      <= ar_idx + MEM_AW'(1);
            rd_beat     <= '0;
            rd_len      <= s_axi_arlen;
            rd_legal    <= ar_legal;
            s_axi_rid   <= s_axi_arid;
            s_axi_rresp <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            s_axi_rdata <= ar_legal ? rd_word : '0;
          end
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            if (rd_beat == rd_len) begin
              rd_state       <= RD_IDLE;
              o_rd_burst_cnt <= o_rd_burst_cnt + 32'd1;
            end else begin
              rd_beat     <= rd_beat + 8'd1;
              rd_idx      <= rd_idx + MEM_AW'(1);
              s_axi_rdata <= rd_legal ? rd_word : '0;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // ---------------- write engine ----------------
  logic [1:0]        wr_state;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] aw_idx;
  logic [7:0]        wr_beat;
  logic [7:0]        wr_len;
  logic              wr_legal;
  logic              wr_perr;
  logic              aw_legal;
  logic              wr_en;

  assign aw_idx   = s_axi_awaddr[MEM_AW+2:3];
  assign aw_legal = (s_axi_awburst == 2'b01) && (s_axi_awsize == 3'b011);

  assign s_axi_awready = (wr_state == WR_IDLE);
  assign s_axi_wready  = (wr_state == WR_DATA);
  assign s_axi_bvalid  = (wr_state == WR_RESP);

  assign wr_en = s_axi_wready && s_axi_wvalid && wr_legal;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < WBYTE_WIDTH; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Beat count, not wlast, ends the burst; wlast disagreement only taints bresp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state       <= WR_IDLE;
      wr_idx         <= '0;
      wr_beat        <= '0;
      wr_len         <= '0;
      wr_legal       <= 1'b0;
      wr_perr        <= 1'b0;
      s_axi_bid      <= '0;
      s_axi_bresp    <= RESP_OKAY;
      o_wr_burst_cnt <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (s_axi_awvalid) begin
            wr_state  <= WR_DATA;
            wr_idx    <= aw_idx;
            wr_beat   <= '0;
            wr_len    <= s_axi_awlen;
            wr_legal  <= aw_legal;
            wr_perr   <= 1'b0;
            s_axi_bid <= s_axi_awid;
          end
        end
        WR_DATA: begin
          if (s_axi_wvalid) begin
            if (wr_beat == wr_len) begin
              wr_state    <= WR_RESP;
              s_axi_bresp <= (!wr_legal || wr_perr || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              wr_beat <= wr_beat + 8'd1;
              wr_idx  <= wr_idx + MEM_AW'(1);
              wr_perr <= wr_perr | s_axi_wlast;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            wr_state       <= WR_IDLE;
            o_wr_burst_cnt <= o_wr_burst_cnt + 32'd1;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule
